// File: rtl/c_result_writer_pkg.sv
// Shared types and default geometry for the C-tile result writer.
package c_result_writer_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int MMS_DEF    = 8;
    localparam int AWIDTH_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

    function automatic logic is_busy(wr_state_e s);
        return (s == ST_ARMED) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/c_result_writer_if.sv
// Producer/BRAM-side bundle of the result writer; master drives tile config and columns.
interface c_result_writer_if
    import c_result_writer_pkg::*;
#(
    parameter int DWIDTH       = DWIDTH_DEF,
    parameter int MAT_MUL_SIZE = MMS_DEF,
    parameter int AWIDTH       = AWIDTH_DEF,
    parameter int CWIDTH       = $clog2(MAT_MUL_SIZE) + 1
) ();

    logic                           start;
    logic [AWIDTH-1:0]              c_addr_base;
    logic [AWIDTH-1:0]              c_addr_stride;
    logic [CWIDTH-1:0]              valid_rows;
    logic [CWIDTH-1:0]              valid_cols;
    logic                           matmul_op_in_progress;
    logic                           c_data_available;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] c_data_in;

    logic [AWIDTH-1:0]              bram_addr_c;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_c;
    logic [MAT_MUL_SIZE-1:0]        bram_we_c;
    logic                           busy;
    logic                           done_write;
    logic                           err_unexpected;

    modport master (
        output start, c_addr_base, c_addr_stride, valid_rows, valid_cols,
               matmul_op_in_progress, c_data_available, c_data_in,
        input  bram_addr_c, bram_wdata_c, bram_we_c, busy, done_write, err_unexpected
    );

    modport slave (
        input  start, c_addr_base, c_addr_stride, valid_rows, valid_cols,
               matmul_op_in_progress, c_data_available, c_data_in,
        output bram_addr_c, bram_wdata_c, bram_we_c, busy, done_write, err_unexpected
    );

endinterface

// File: rtl/c_result_writer.sv
// Writes one MMS-column C tile into BRAM; each accepted column appears on the port 1 cycle later.
// No backpressure: a column is taken whenever c_data_available is high while armed/writing.
module c_result_writer
    import c_result_writer_pkg::*;
#(
    parameter int DWIDTH       = DWIDTH_DEF,
    parameter int MAT_MUL_SIZE = MMS_DEF,
    parameter int AWIDTH       = AWIDTH_DEF,
    parameter int CWIDTH       = $clog2(MAT_MUL_SIZE) + 1
) (
    input  logic              clk,
    input  logic              reset,
    c_result_writer_if.slave  bus
);

    localparam int WWIDTH = MAT_MUL_SIZE * DWIDTH;

    wr_state_e               state_q, state_d;
    logic [CWIDTH-1:0]       col_q, col_d;
    logic [AWIDTH-1:0]       addr_acc_q, addr_acc_d;
    logic [AWIDTH-1:0]       stride_q, stride_d;
    logic [CWIDTH-1:0]       rows_q, rows_d;
    logic [CWIDTH-1:0]       cols_q, cols_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic [AWIDTH-1:0]       addr_out_q, addr_out_d;
    logic [WWIDTH-1:0]       wdata_q, wdata_d;
    logic [MAT_MUL_SIZE-1:0] we_q, we_d;
    logic                    col_in_range;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        addr_acc_d   = addr_acc_q;
        stride_d     = stride_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        err_d        = err_q;
        addr_out_d   = addr_out_q;
        wdata_d      = wdata_q;
        we_d         = '0;
        // completion is flagged the cycle after the last write is on the port
        done_d       = (state_q == ST_DONE);
        col_in_range = (col_q < cols_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_ARMED;
                    col_d      = '0;
                    addr_acc_d = bus.c_addr_base;
                    stride_d   = bus.c_addr_stride;
                    rows_d     = bus.valid_rows;
                    cols_d     = bus.valid_cols;
                    err_d      = 1'b0;
                end else if (bus.c_data_available) begin
                    err_d = 1'b1;
                end
            end
            ST_ARMED, ST_WRITE: begin
                if (!bus.matmul_op_in_progress) begin
                    state_d = ST_IDLE;
                end else if (bus.c_data_available) begin
                    addr_out_d = addr_acc_q;
                    wdata_d    = bus.c_data_in;
                    for (int r = 0; r < MAT_MUL_SIZE; r++) begin
                        we_d[r] = (CWIDTH'(r) < rows_q) && col_in_range;
                    end
                    // running base + col*stride, wrapping at the address width
                    addr_acc_d = addr_acc_q + stride_q;
                    col_d      = col_q + CWIDTH'(1);
                    state_d    = (col_q == CWIDTH'(MAT_MUL_SIZE - 1)) ? ST_DONE : ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            addr_acc_q <= '0;
            stride_q   <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            addr_out_q <= '0;
            wdata_q    <= '0;
            we_q       <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            addr_acc_q <= addr_acc_d;
            stride_q   <= stride_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            err_q      <= err_d;
            done_q     <= done_d;
            addr_out_q <= addr_out_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
        end
    end

    assign bus.bram_addr_c    = addr_out_q;
    assign bus.bram_wdata_c   = wdata_q;
    assign bus.bram_we_c      = we_q;
    assign bus.busy           = is_busy(state_q);
    assign bus.done_write     = done_q;
    assign bus.err_unexpected = err_q;

endmodule

// File: doc/c_result_writer.md
C_RESULT_WRITER -- requirements
Module: c_result_writer

Interface
REQ-001 Parameter DWIDTH, default 8, element width in bits.
REQ-002 Parameter MAT_MUL_SIZE, default 8, elements per column word and columns per tile (MMS).
REQ-003 Parameter AWIDTH, default 10, C-buffer address width.
REQ-004 Parameter CWIDTH, default $clog2(MAT_MUL_SIZE)+1, width of the row/column count fields.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse that arms a tile write and latches the configuration inputs.
REQ-008 c_addr_base  in  AWIDTH  address for column 0.
REQ-009 c_addr_stride  in  AWIDTH  address increment per column.
REQ-010 valid_rows  in  CWIDTH  number of valid rows, 1..MMS.
REQ-011 valid_cols  in  CWIDTH  number of valid columns, 1..MMS.
REQ-012 matmul_op_in_progress  in  1  low aborts the tile.
REQ-013 c_data_available  in  1  c_data_in carries one column this cycle.
REQ-014 c_data_in  in  MMS*DWIDTH  column word; lane r = bits [r*DWIDTH +: DWIDTH] = row r.
REQ-015 bram_addr_c  out  AWIDTH  write address.
REQ-016 bram_wdata_c  out  MMS*DWIDTH  write data.
REQ-017 bram_we_c  out  MMS  per-lane write enable.
REQ-018 busy  out  1  high in ARMED or WRITE.
REQ-019 done_write  out  1  one-cycle completion pulse.
REQ-020 err_unexpected  out  1  sticky flag: data arrived while IDLE.

Function
REQ-021 States are IDLE, ARMED, WRITE and DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-022 IDLE->ARMED on start: latch base, stride, valid_rows and valid_cols; clear err_unexpected; clear column counter col=0.
REQ-023 ARMED->WRITE on the first accepted column; a column is accepted when c_data_available=1 in ARMED or WRITE.
REQ-024 Accepted column col is registered onto the BRAM port next cycle (latency 1):
  - bram_addr_c = base + col*stride, computed by running add (no multiplier), mod 2^AWIDTH.
  - bram_wdata_c = c_data_in.
  - bram_we_c[r] = 1 iff r < valid_rows and col < valid_cols, else 0.
REQ-025 col increments per accepted column; c_data_available=0 in WRITE stalls with we=0 and no counter change.
REQ-026 After MMS columns are accepted, go to DONE; done_write=1 in the cycle after the last write is presented.
REQ-027 Columns beyond MMS are ignored (producer keeps shifting zeros), so no write occurs after DONE.
REQ-028 start while busy or in DONE is ignored.
REQ-029 matmul_op_in_progress=0 in ARMED or WRITE -> IDLE next cycle, we=0, no done_write; writes already issued stand.
REQ-030 c_data_available=1 in IDLE sets err_unexpected and causes no write.
REQ-031 If start and c_data_available are both 1 in IDLE, the data is not accepted and err_unexpected is not set.
REQ-032 bram_we_c=0 in every cycle without a registered accepted column.

Reset
REQ-033 reset forces IDLE, col=0, bram_addr_c=0, bram_wdata_c=0, bram_we_c=0, busy=0, done_write=0, err_unexpected=0 on the next edge, including mid-tile.
REQ-034 reset takes precedence over every other input.

Structure
REQ-035 A shared package holds the state enum and the DWIDTH/MAT_MUL_SIZE/AWIDTH defaults, shared with the output logic stage.
REQ-036 A single flat module with no sub-modules; the address generator is an in-module accumulator.

Verification
REQ-037 Full tile: start with base=0x040, stride=1, rows=cols=8, then 8 consecutive columns -> writes at 0x040..0x047, we=0xFF each, done_write pulses once, 9th column not written.
REQ-038 Stall: 8 columns with c_data_available low for 2 cycles after column 3 -> identical addresses and data, no write during the gap, done delayed 2 cycles.
REQ-039 Partial tile: rows=5, cols=6 -> columns 0..5 with we=0x1F, columns 6..7 with we=0x00, done_write after column 7.
REQ-040 Wrap: base=0x3FE, stride=0x003, AWIDTH=10 -> addresses 0x3FE, 0x001, 0x004, ..., 0x013.
REQ-041 Abort: matmul_op_in_progress dropped after column 4 -> IDLE, no done_write, exactly 4 writes seen; a later start runs normally.
REQ-042 Error/reset: data in IDLE -> err_unexpected=1 until next start; reset asserted mid-tile -> all outputs 0 the next cycle.
